// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 instruction codes, length helpers and encoder state type.
// Shared by the encoder and the fetch stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REG,
    S_VALC,
    S_STOPPED
  } enc_state_e;

  function automatic logic need_regids(input logic [3:0] icode);
    return icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic need_valC(input logic [3:0] icode);
    return icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
  endfunction

endpackage

// File: rtl/y86_ilen.sv
// rtl/y86_ilen.sv - Combinational icode decode: byte-field presence, length, validity.
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic [3:0] len_o,
  output logic       valid_o
);

  assign need_regids_o = need_regids(icode_i);
  assign need_valc_o   = need_valC(icode_i);
  assign len_o         = 4'd1 + {3'b000, need_regids_o} + (need_valc_o ? 4'd8 : 4'd0);
  assign valid_o       = (icode_i < 4'hC);

endmodule

// File: rtl/imem_encoder.sv
// rtl/imem_encoder.sv - Serializes Y86 instruction fields into instruction-memory byte writes.
// Optional IMEM_ENC_HALT_STOP_EN: encoder stops after writing a halt until start_i.
module imem_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifun_i,
  input  logic [3:0]        rA_i,
  input  logic [3:0]        rB_i,
  input  logic [63:0]       valC_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [15:0]       instr_cnt_o,
  output logic              err_o,
  output logic              bad_instr_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  enc_state_e        state, next_state;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
  logic [63:0]       valc_q;
  logic              need_regids_q, need_valc_q;
  logic [2:0]        idx_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [15:0]       cnt_q;
  logic              err_q, bad_q, ovf_q;

  logic              need_regids_w, need_valc_w, icode_ok_w;
  logic [3:0]        len_w;
  logic [ADDR_W:0]   end_addr;
  logic              fits, accept, take, wr, last;
  logic [7:0]        byte_w;

  y86_ilen u_ilen (
    .icode_i       (icode_i),
    .need_regids_o (need_regids_w),
    .need_valc_o   (need_valc_w),
    .len_o         (len_w),
    .valid_o       (icode_ok_w)
  );

  // Extra bit so an instruction ending exactly at MEM_BYTES is still accepted
  assign end_addr = {1'b0, ptr_q} + (ADDR_W+1)'(len_w);
  assign fits     = (end_addr <= MEM_LIMIT);
  assign accept   = in_valid_i & in_ready_o;
  assign take     = accept & icode_ok_w & fits;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr         = 1'b0;
    last       = 1'b0;
    byte_w     = 8'h00;
    case (state)
      S_IDLE: if (take) next_state = S_HDR;
      S_HDR: begin
        wr     = 1'b1;
        byte_w = {icode_q, ifun_q};
        if (need_regids_q)    next_state = S_REG;
        else if (need_valc_q) next_state = S_VALC;
        else begin
          last = 1'b1;
`ifdef IMEM_ENC_HALT_STOP_EN
          next_state = (icode_q == I_HALT) ? S_STOPPED : S_IDLE;
`else
          next_state = S_IDLE;
`endif
        end
      end
      S_REG: begin
        wr     = 1'b1;
        byte_w = {ra_q, rb_q};
        if (need_valc_q) next_state = S_VALC;
        else begin
          last       = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_VALC: begin
        wr     = 1'b1;
        byte_w = valc_q[{idx_q, 3'b000} +: 8];
        if (idx_q == 3'd7) begin
          last       = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_STOPPED: next_state = S_STOPPED;
      default:   next_state = S_IDLE;
    endcase
    // start_i abandons whatever is in flight, including this cycle's byte
    if (start_i) begin
      next_state = S_IDLE;
      wr         = 1'b0;
      last       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      icode_q       <= 4'h0;
      ifun_q        <= 4'h0;
      ra_q          <= 4'h0;
      rb_q          <= 4'h0;
      valc_q        <= 64'h0;
      need_regids_q <= 1'b0;
      need_valc_q   <= 1'b0;
      idx_q         <= 3'd0;
      ptr_q         <= ADDR_W'(BASE_ADDR);
      cnt_q         <= 16'h0;
      err_q         <= 1'b0;
      bad_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      err_q <= accept & ~take;
      if (start_i) begin
        ptr_q <= start_addr_i;
        if (state == S_IDLE) begin
          bad_q <= 1'b0;
          ovf_q <= 1'b0;
        end
      end else if (wr) begin
        ptr_q <= ptr_q + 1'b1;
      end
      if (accept && !icode_ok_w)  bad_q <= 1'b1;
      else if (accept && !fits)   ovf_q <= 1'b1;
      if (take) begin
        icode_q       <= icode_i;
        ifun_q        <= ifun_i;
        ra_q          <= rA_i;
        rb_q          <= rB_i;
        valc_q        <= valC_i;
        need_regids_q <= need_regids_w;
        need_valc_q   <= need_valc_w;
        idx_q         <= 3'd0;
      end else if (wr && state == S_VALC) begin
        idx_q <= idx_q + 3'd1;
      end
      if (last) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign in_ready_o  = (state == S_IDLE) & ~start_i;
  assign wr_en_o     = wr;
  assign wr_addr_o   = wr ? ptr_q : '0;
  assign wr_data_o   = byte_w;
  assign ptr_o       = ptr_q;
  assign instr_cnt_o = cnt_q;
  assign err_o       = err_q;
  assign bad_instr_o = bad_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/imem_encoder.md
Name: imem_encoder

Overview:
- Writer side of the Y86 instruction-memory interface: accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake.
- Serializes each instruction into the byte layout the fetch stage decodes, emitting one byte-write per cycle into instruction memory.
- Used by the program loader and testbenches to assemble programs in-system.
- Tracks the next free address, which equals valP of the last written instruction.

Parameters:
ADDR_W, 10, width of byte address.
MEM_BYTES, 1024, instruction memory size in bytes.
BASE_ADDR, 0, write pointer value after reset.

Ports:
clk_i  input  1  clock, rising edge.
rst_n_i  input  1  asynchronous active-low reset.
start_i  input  1  load write pointer from start_addr_i and clear error flags.
start_addr_i  input  ADDR_W  new write pointer.
in_valid_i  input  1  instruction fields valid.
in_ready_o  output  1  encoder can accept an instruction.
icode_i  input  4  instruction code.
ifun_i  input  4  function code.
rA_i  input  4  register A.
rB_i  input  4  register B.
valC_i  input  64  constant.
wr_en_o  output  1  byte write strobe.
wr_addr_o  output  ADDR_W  byte address.
wr_data_o  output  8  byte data.
ptr_o  output  ADDR_W  next free address.
instr_cnt_o  output  16  instructions fully written, wraps at 0xFFFF->0.
err_o  output  1  one-cycle pulse on a rejected instruction.
bad_instr_o  output  1  sticky: icode >= 0xC was offered.
ovf_o  output  1  sticky: instruction would exceed MEM_BYTES.

Behaviour:
- Reset (async, rst_n_i low): state IDLE; ptr_o = BASE_ADDR; wr_en_o, wr_addr_o, wr_data_o, instr_cnt_o, err_o, bad_instr_o, ovf_o = 0; in_ready_o = 1. Reset mid-emission abandons the instruction; bytes already written remain in memory.
- in_ready_o = (state == IDLE) & ~start_i. Accept occurs when in_valid_i & in_ready_o. Fields are registered on accept.
- Length rules:
  - need_regids for icode in {2,3,4,5,6,A,B}.
  - need_valC for icode in {3,4,5,7,8}.
  - len = 1 + need_regids + 8*need_valC, giving 1, 2, 9 or 10 bytes.
- Rejection on accept, in priority order (no writes; ptr_o unchanged; err_o pulses the next cycle; state stays IDLE):
  - icode >= 0xC -> bad_instr_o set.
  - ptr_o + len > MEM_BYTES (compared at ADDR_W+1 bits) -> ovf_o set.
- States: IDLE -> HDR -> (REG if need_regids) -> (VALC if need_valC, byte index 0..7) -> IDLE.
  - HDR writes {icode, ifun}.
  - REG writes {rA, rB}.
  - VALC writes valC little-endian, least-significant byte at the lowest address.
  - One byte per cycle. wr_addr_o = ptr_o, and ptr_o increments on each write.
- Latency: the first write occurs the cycle after accept. in_ready_o returns in the cycle after the last byte, so one instruction occupies len+1 cycles.
- instr_cnt_o increments on the cycle the last byte is written.
- start_i:
  - In IDLE: loads ptr_o and clears bad_instr_o and ovf_o.
  - In any other state: aborts the current instruction, loads ptr_o and returns to IDLE. No write occurs that cycle; instr_cnt_o is not incremented.
- start_i has priority over accept, because in_ready_o is forced low while start_i is high.
- Fields whose corresponding bytes are not emitted are ignored: rA/rB when need_regids is 0, valC when need_valC is 0.

Optional Feature:
IMEM_ENC_HALT_STOP_EN:
- Defined: after a halt (icode 0) byte is written, the encoder enters STOPPED, with in_ready_o = 0 and no writes. Only start_i or reset leaves STOPPED.
- Undefined: halt is an ordinary 1-byte instruction and the encoder returns to IDLE.

Decomposition:
- Package y86_pkg holds:
  - icode constants I_HALT..I_POPQ (0x0..0xB).
  - REG_NONE = 4'hF.
  - Functions need_regids(icode) and need_valC(icode), shared with the fetch stage.
  - Encoder state enum.
- Sub-module y86_ilen: combinational block mapping icode to need_regids, need_valC, len and icode-valid.

Test Plan:
- ptr 0, irmovq (icode 3, ifun 0, rA F, rB 2, valC 0x100) -> bytes 30 F2 00 01 00 00 00 00 00 00 at addresses 0..9; ptr_o = 10; instr_cnt_o = 1; in_ready_o high 11 cycles after accept.
- Then nop (icode 1) and addq (icode 6, ifun 0, rA 0, rB 3) -> addr 10 = 10, addr 11 = 60, addr 12 = 03; ptr_o = 13; instr_cnt_o = 3.
- jmp (icode 7, valC 0x40) at ptr 13 -> 70 40 00 00 00 00 00 00 00 at addresses 13..21; no register byte.
- icode 0xD offered -> no wr_en_o; err_o one-cycle pulse; bad_instr_o = 1; ptr_o unchanged; then start_i clears bad_instr_o.
- start_addr 1020, irmovq offered -> ovf_o = 1; no writes; ptr_o = 1020. Then nop offered -> writes addr 1020; ptr_o = 1021.
- rst_n_i low after 3 bytes of an irmovq -> all outputs 0 and ptr_o = BASE_ADDR immediately; in_ready_o = 1 after release.
